// File: rtl/mpu_defs.sv
// ============================================================================
// Module      : mpu_defs (package)
// Description : Shared constants, FSM state encoding and the matrix
//               element-offset helper for the MPU matrix loader.
//               ELEM_W / N_MAX / MAT_W / ROW_W describe the flat 5x5 int8
//               matrix bus; elem_off(r,c) = r*40 + c*8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mpu_defs;

    localparam int ELEM_W = 8;
    localparam int N_MAX  = 5;
    localparam int MAT_W  = 200;
    localparam int ROW_W  = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Bit offset of element (r,c) inside the [0:199] matrix bus.
    function automatic logic [7:0] elem_off(input logic [2:0] r, input logic [2:0] c);
        return 8'(r) * 8'(ROW_W) + 8'(c) * 8'(ELEM_W);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mpu_loader_index.sv
// ============================================================================
// Module      : mpu_loader_index
// Description : Combinational address stepper for the matrix loader.
//               From the current (row,col) cursor, the dimension N and the
//               number of elements still to load, produces per-lane target
//               addresses and write enables, the advanced cursor, the
//               remaining count after this beat and the done flag.
//               Optional macro MPU_LOADER_TRANSPOSE_EN: lane addresses are
//               emitted as (col,row), i.e. the stream is column-major.
// Ports       : row_i/col_i   current cursor
//               n_i           matrix dimension (1..5)
//               rem_i         elements still to load
//               lane_row_o/lane_col_o/lane_we_o  per-lane write target
//               row_next_o/col_next_o/rem_next_o cursor after this beat
//               done_o        this beat writes the final element
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpu_loader_index
    import mpu_defs::*;
#(
    parameter int LANES = 4
) (
    input  logic [2:0]             row_i,
    input  logic [2:0]             col_i,
    input  logic [2:0]             n_i,
    input  logic [4:0]             rem_i,
    output logic [LANES-1:0][2:0]  lane_row_o,
    output logic [LANES-1:0][2:0]  lane_col_o,
    output logic [LANES-1:0]       lane_we_o,
    output logic [2:0]             row_next_o,
    output logic [2:0]             col_next_o,
    output logic [4:0]             rem_next_o,
    output logic                   done_o
);

    logic [4:0] w_take;

    always_comb begin
        logic [2:0] r;
        logic [2:0] c;
        r          = row_i;
        c          = col_i;
        lane_row_o = '0;
        lane_col_o = '0;
        lane_we_o  = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef MPU_LOADER_TRANSPOSE_EN
            lane_row_o[k] = c;
            lane_col_o[k] = r;
`else
            lane_row_o[k] = r;
            lane_col_o[k] = c;
`endif
            // Lanes past the final element neither write nor advance.
            lane_we_o[k] = (5'(k) < rem_i);
            if (lane_we_o[k]) begin
                if (c == n_i - 3'd1) begin
                    c = 3'd0;
                    r = r + 3'd1;
                end else begin
                    c = c + 3'd1;
                end
            end
        end
        row_next_o = r;
        col_next_o = c;
    end

    assign w_take     = (rem_i > 5'(LANES)) ? 5'(LANES) : rem_i;
    assign rem_next_o = rem_i - w_take;
    assign done_o     = (rem_next_o == 5'd0);

endmodule

`default_nettype wire

// File: rtl/mpu_matrix_loader.sv
// ============================================================================
// Module      : mpu_matrix_loader
// Description : Feeder for the MPU determinant stage. Takes a size command,
//               then LANES int8 elements per beat in row-major order, builds
//               the flat 5x5 matrix bus and holds it under valid/ready until
//               the consumer takes it.
//               Optional macro MPU_LOADER_TRANSPOSE_EN (in mpu_loader_index):
//               treat the element stream as column-major.
// Ports       : clock, reset_n (async, active-low)
//               start/size     load command (size legal 1..N_MAX), IDLE only
//               in_valid/in_ready/in_data   element beats, lane 0 first
//               out_valid/out_ready         matrix handshake
//               matrix [0:199] element (r,c) at r*40+c*8 +: 8
//               size_out       latched N
//               err            one-cycle pulse for an illegal size
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpu_matrix_loader
    import mpu_defs::*;
#(
    parameter int LANES = 4,
    parameter int N_MAX = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [7:0]           size,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:MAT_W-1]     matrix,
    output logic [7:0]           size_out,
    output logic                 err
);

    state_t             state_q, state_d;
    logic [0:MAT_W-1]   matrix_q, matrix_d;
    logic [7:0]         size_q, size_d;
    logic [2:0]         row_q, row_d, col_q, col_d;
    logic [4:0]         rem_q, rem_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;

    logic                   w_size_ok;
    logic                   w_beat;
    logic                   w_hs;
    logic [LANES-1:0][2:0]  w_lane_row;
    logic [LANES-1:0][2:0]  w_lane_col;
    logic [LANES-1:0]       w_lane_we;
    logic [2:0]             w_row_next, w_col_next;
    logic [4:0]             w_rem_next;
    logic                   w_done;

    // Unsigned compare also rejects negative int8 sizes (0x80..0xFF).
    assign w_size_ok = (size >= 8'd1) && (size <= 8'(N_MAX));
    assign w_beat    = in_valid & in_ready_q;
    assign w_hs      = out_valid_q & out_ready;

    mpu_loader_index #(
        .LANES (LANES)
    ) u_index (
        .row_i      (row_q),
        .col_i      (col_q),
        .n_i        (size_q[2:0]),
        .rem_i      (rem_q),
        .lane_row_o (w_lane_row),
        .lane_col_o (w_lane_col),
        .lane_we_o  (w_lane_we),
        .row_next_o (w_row_next),
        .col_next_o (w_col_next),
        .rem_next_o (w_rem_next),
        .done_o     (w_done)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start && w_size_ok) state_d = ST_LOAD;
            ST_LOAD: if (w_beat && w_done)   state_d = ST_HOLD;
            ST_HOLD: if (w_hs)               state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        matrix_d    = matrix_q;
        size_d      = size_q;
        row_d       = row_q;
        col_d       = col_q;
        rem_d       = rem_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (w_size_ok) begin
                        matrix_d   = '0;
                        size_d     = size;
                        row_d      = 3'd0;
                        col_d      = 3'd0;
                        rem_d      = 5'(size[2:0]) * 5'(size[2:0]);
                        in_ready_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_beat) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (w_lane_we[k]) begin
                            matrix_d[elem_off(w_lane_row[k], w_lane_col[k]) +: ELEM_W] =
                                in_data[ELEM_W*k +: ELEM_W];
                        end
                    end
                    row_d = w_row_next;
                    col_d = w_col_next;
                    rem_d = w_rem_next;
                    if (w_done) begin
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_hs) out_valid_d = 1'b0;
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            matrix_q    <= '0;
            size_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            matrix_q    <= matrix_d;
            size_q      <= size_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rem_q       <= rem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign matrix    = matrix_q;
    assign size_out  = size_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mpu_matrix_loader.sv
// ============================================================================
// Module      : tb_mpu_matrix_loader
// Description : Self-checking bench for mpu_matrix_loader (LANES=4).
//               A transaction-level model (element index k -> (k/N, k%N))
//               is compared against the DUT on every falling edge, plus
//               literal spot checks after each directed scenario.
//               Honors MPU_LOADER_TRANSPOSE_EN for the expected mapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mpu_matrix_loader;

    localparam int LANES = 4;

    logic                clock    = 1'b0;
    logic                reset_n  = 1'b0;
    logic                start    = 1'b0;
    logic [7:0]          size     = 8'd0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [8*LANES-1:0]  in_data  = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [0:199]        matrix;
    logic [7:0]          size_out;
    logic                err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mpu_matrix_loader #(
        .LANES (LANES),
        .N_MAX (5)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .size      (size),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .matrix    (matrix),
        .size_out  (size_out),
        .err       (err)
    );

    // ---------------- behavioural model ----------------
    int         m_mode;          // 0 idle, 1 loading, 2 holding
    int         m_n;
    int         m_k;
    logic [7:0] m_mat [5][5];
    logic       m_rdy;
    logic       m_ov;
    logic       m_err;
    logic [7:0] m_size;

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_k = 0;
        m_rdy = 1'b0; m_ov = 1'b0; m_err = 1'b0; m_size = 8'd0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                m_mat[r][c] = 8'd0;
    endtask

    task automatic model_step();
        int r;
        int c;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_err = 1'b0;
        case (m_mode)
            0: begin
                if (start) begin
                    if ($signed(size) >= 1 && $signed(size) <= 5) begin
                        for (int i = 0; i < 5; i++)
                            for (int j = 0; j < 5; j++)
                                m_mat[i][j] = 8'd0;
                        m_size = size;
                        m_n    = int'(size);
                        m_k    = 0;
                        m_mode = 1;
                        m_rdy  = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            1: begin
                if (in_valid) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (m_k < m_n * m_n) begin
                            r = m_k / m_n;
                            c = m_k % m_n;
`ifdef MPU_LOADER_TRANSPOSE_EN
                            m_mat[c][r] = in_data[8*l +: 8];
`else
                            m_mat[r][c] = in_data[8*l +: 8];
`endif
                            m_k++;
                        end
                    end
                    if (m_k == m_n * m_n) begin
                        m_mode = 2;
                        m_rdy  = 1'b0;
                        m_ov   = 1'b1;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    m_mode = 0;
                    m_ov   = 1'b0;
                end
            end
        endcase
    endtask

    function automatic logic [0:199] model_flat();
        logic [0:199] f;
        f = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                f[r*40 + c*8 +: 8] = m_mat[r][c];
        return f;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] el(input int r, input int c);
        return matrix[r*40 + c*8 +: 8];
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_take", 200'(out_valid), 200'(1'b0));
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                chk("cyc_in_ready",  200'(in_ready),  200'(m_rdy));
                chk("cyc_out_valid", 200'(out_valid), 200'(m_ov));
                chk("cyc_err",       200'(err),       200'(m_err));
                chk("cyc_size_out",  200'(size_out),  200'(m_size));
                chk("cyc_matrix",    matrix,          model_flat());
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0]  beats3 [3];
    logic         pat3   [5];
    logic [7:0]   bad_sizes [3];
    logic [0:199] exp_mat;
    int           bi;

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready",  200'(in_ready),  200'(1'b0));
        chk("rst_out_valid", 200'(out_valid), 200'(1'b0));
        chk("rst_err",       200'(err),       200'(1'b0));
        chk("rst_size_out",  200'(size_out),  200'(8'd0));
        chk("rst_matrix",    matrix,          200'(0));
        reset_n = 1'b1;
        tick();

        // Test 1: N=2, one beat
        size = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_in_ready", 200'(in_ready), 200'(1'b1));
        in_valid = 1'b1; in_data = 32'h04030201;
        tick();
        in_valid = 1'b0; in_data = '0;
        chk("t1_out_valid", 200'(out_valid), 200'(1'b1));
        chk("t1_e00", 200'(el(0,0)), 200'(8'd1));
`ifdef MPU_LOADER_TRANSPOSE_EN
        chk("t1_e01", 200'(el(0,1)), 200'(8'd3));
        chk("t1_e10", 200'(el(1,0)), 200'(8'd2));
`else
        chk("t1_e01", 200'(el(0,1)), 200'(8'd2));
        chk("t1_e10", 200'(el(1,0)), 200'(8'd3));
`endif
        chk("t1_e11", 200'(el(1,1)), 200'(8'd4));
        chk("t1_e02", 200'(el(0,2)), 200'(8'd0));
        chk("t1_e20", 200'(el(2,0)), 200'(8'd0));
        chk("t1_size_out", 200'(size_out), 200'(8'd2));
        handshake();

        // Test 2: N=5, seven beats of 1..25, trailing lanes 0xFF
        size = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int b = 0; b < 7; b++) begin
            for (int l = 0; l < LANES; l++)
                in_data[8*l +: 8] = (4*b + l + 1 <= 25) ? 8'(4*b + l + 1) : 8'hFF;
            if (b == 6) chk("t2_not_yet_valid", 200'(out_valid), 200'(1'b0));
            tick();
        end
        in_valid = 1'b0; in_data = '0;
        chk("t2_out_valid", 200'(out_valid), 200'(1'b1));
        chk("t2_e44", 200'(el(4,4)), 200'(8'd25));
`ifdef MPU_LOADER_TRANSPOSE_EN
        chk("t2_e23", 200'(el(2,3)), 200'(8'd18));
`else
        chk("t2_e23", 200'(el(2,3)), 200'(8'd14));
`endif
        chk("t2_e00", 200'(el(0,0)), 200'(8'd1));
        handshake();

        // Test 3: N=3, gapped input, long hold
        beats3[0] = 32'h04030201; beats3[1] = 32'h08070605; beats3[2] = 32'hEEEEEE09;
        pat3[0] = 1'b1; pat3[1] = 1'b0; pat3[2] = 1'b1; pat3[3] = 1'b0; pat3[4] = 1'b1;
        size = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        bi = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = pat3[i];
            if (pat3[i]) begin
                in_data = beats3[bi];
                bi++;
            end else begin
                in_data = 32'hDEADBEEF;
            end
            tick();
        end
        in_valid = 1'b0; in_data = '0;
        chk("t3_out_valid", 200'(out_valid), 200'(1'b1));
        chk("t3_e22", 200'(el(2,2)), 200'(8'd9));
`ifdef MPU_LOADER_TRANSPOSE_EN
        chk("t3_e01", 200'(el(0,1)), 200'(8'd4));
`else
        chk("t3_e01", 200'(el(0,1)), 200'(8'd2));
`endif
        repeat (10) tick();
        chk("t3_held_valid", 200'(out_valid), 200'(1'b1));
        chk("t3_held_e22", 200'(el(2,2)), 200'(8'd9));
        handshake();
        chk("t3_size_kept", 200'(size_out), 200'(8'd3));

        // Test 4: illegal sizes
        bad_sizes[0] = 8'd0; bad_sizes[1] = 8'd6; bad_sizes[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            size = bad_sizes[i]; start = 1'b1;
            tick();
            start = 1'b0;
            chk("t4_err_pulse", 200'(err), 200'(1'b1));
            chk("t4_in_ready", 200'(in_ready), 200'(1'b0));
            tick();
            chk("t4_err_clear", 200'(err), 200'(1'b0));
            chk("t4_size_kept", 200'(size_out), 200'(8'd3));
        end

        // Test 5: reset mid-load, then N=1 load
        size = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h04030201;
        tick();
        in_data = 32'h08070605;
        start = 1'b1; size = 8'd0;   // ignored outside IDLE
        tick();
        in_valid = 1'b0; start = 1'b0; in_data = '0;
        chk("t5_no_err_in_load", 200'(err), 200'(1'b0));
        chk("t5_in_ready", 200'(in_ready), 200'(1'b1));
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_in_ready",  200'(in_ready),  200'(1'b0));
        chk("t5_rst_out_valid", 200'(out_valid), 200'(1'b0));
        chk("t5_rst_matrix",    matrix,          200'(0));
        chk("t5_rst_size_out",  200'(size_out),  200'(8'd0));
        tick();
        reset_n = 1'b1;
        tick();
        size = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'hAAAAAA80;
        tick();
        in_valid = 1'b0; in_data = '0;
        exp_mat = '0;
        exp_mat[0:7] = 8'h80;
        chk("t5_out_valid", 200'(out_valid), 200'(1'b1));
        chk("t5_matrix", matrix, exp_mat);
        chk("t5_size_out", 200'(size_out), 200'(8'd1));
        handshake();

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mpu_matrix_loader.md
Name: mpu_matrix_loader

Overview:
Upstream feeder of the MPU determinant stage. It accepts a size command, then a stream of signed int8 elements packed LANES per beat, in row-major order. It assembles them into the flat 5x5 matrix bus and holds that bus stable with a valid/ready handshake, so the determinant stage sees a constant operand for its whole multi-cycle evaluation.

Parameters:
LANES, 4, int8 elements per input beat (1..5)
N_MAX, 5, maximum matrix dimension (fixed; storage is always 25 elements)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle command pulse; sampled only in IDLE
size  in  8  matrix dimension N, signed int8; legal range 1..5
in_valid  in  1  input beat valid
in_ready  out  1  loader accepts a beat this cycle
in_data  in  8*LANES  lane k = in_data[8k+7:8k]; lane 0 is the earliest element
out_valid  out  1  matrix/size_out are complete and stable
out_ready  in  1  consumer has taken the matrix
matrix  out  200  declared [0:199]; element (r,c) = matrix[r*40+c*8 +: 8]
size_out  out  8  latched N
err  out  1  one-cycle pulse: start received with an illegal size

Behaviour:
- Reset (async, reset_n=0): state=IDLE; matrix=0; size_out=0; in_ready=0; out_valid=0; err=0; counters=0. Assertion mid-load or mid-hold aborts the operation; partial data is discarded.
- States: IDLE, LOAD, HOLD.
- IDLE, start=1, 1<=size<=5:
  - next cycle: LOAD; matrix cleared to 0; size_out=size; row=col=0; remaining=N*N.
- IDLE, start=1, size outside 1..5:
  - err=1 for exactly one cycle; stay in IDLE; matrix and size_out unchanged.
- start outside IDLE is ignored and produces no err.
- LOAD:
  - in_ready=1 (registered; asserted the cycle after LOAD is entered).
  - Beat accepted when in_valid & in_ready.
  - Lanes 0..min(LANES,remaining)-1 are written in order to (row,col). col increments; on col==N-1 it wraps to 0 and row increments.
  - Lanes beyond remaining are ignored.
  - Elements with r>=N or c>=N are never written and stay 0.
- Last element written: next cycle state=HOLD, in_ready=0, out_valid=1. Minimum latency from start to out_valid = 1 + ceil(N*N/LANES) cycles with in_valid held high.
- HOLD:
  - matrix, size_out and out_valid are held constant until out_valid & out_ready.
  - On that handshake, next cycle: IDLE, out_valid=0. matrix and size_out keep their values until the next legal start.
- out_ready while not in HOLD has no effect.
- in_valid while not in LOAD has no effect; no beat is consumed.
- Data is stored bit-exact; no arithmetic is applied to element values.

Optional Feature:
MPU_LOADER_TRANSPOSE_EN
- Defined: element k is written to (col,row) instead of (row,col), i.e. the input stream is treated as column-major. Only the counter-to-address mapping changes; timing is identical.
- Undefined: row-major only; no transpose logic is synthesized.

Decomposition:
- Shared package/header mpu_defs: ELEM_W=8, N_MAX=5, MAT_W=200, ROW_W=40, the element-offset macro (r*40+c*8), and the state encodings.
- One sub-module, mpu_loader_index: combinational stepper. Given row, col, N and a lane count, it outputs per-lane (row,col) addresses, per-lane write enables, next row/col, and the done flag. The top level keeps only the FSM, the handshake and the matrix register.

Test Plan:
1. LANES=4, start size=2, one beat in_data=0x04030201 -> next cycle out_valid=1; (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4; all other elements 0; size_out=2.
2. size=5, seven beats carrying values 1..25 (beat 7 lane 0 = 25, lanes 1-3 = 0xFF) -> (4,4)=25, (2,3)=14; 0xFF is never stored; out_valid asserts the cycle after beat 7.
3. size=3, in_valid toggled 1,0,1,0,1 -> exactly 3 beats consumed (9 elements); (2,2) = 9th element; out_valid held 10 cycles with out_ready=0, matrix unchanged; out_ready=1 -> out_valid=0 the next cycle.
4. start with size=0, then size=6, then size=-1 (8'hFF) -> err pulses once per start; state stays IDLE; in_ready stays 0.
5. size=4, reset_n pulsed low after 2 beats -> all outputs 0 immediately. After release, a fresh size=1 load with element 0x80 -> matrix[0 +: 8]=8'h80, all other elements 0.
6. MPU_LOADER_TRANSPOSE_EN defined, size=2, beat 0x04030201 -> (0,1)=3, (1,0)=2; diagonal unchanged.
